// File: rtl/ex_stage_pkg.sv
// ex_pkg: op codes, exception causes and FSM encoding shared by the execute stage.
// EX_STAGE_TRAP_EN selects whether the TRAP/HALT states exist.
package ex_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_ILL0 = 3'b011;
    localparam logic [2:0] OP_NOR  = 3'b100;
    localparam logic [2:0] OP_XOR  = 3'b101;
    localparam logic [2:0] OP_SUB  = 3'b110;
    localparam logic [2:0] OP_ILL1 = 3'b111;

    localparam logic [1:0] CAUSE_NONE = 2'b00;
    localparam logic [1:0] CAUSE_OVF  = 2'b01;
    localparam logic [1:0] CAUSE_ILL  = 2'b10;

`ifdef EX_STAGE_TRAP_EN
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FULL = 2'd1,
        TRAP = 2'd2,
        HALT = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FULL = 2'd1
    } state_t;
`endif

    // Both unused op codes end in 2'b11.
    function automatic logic is_illegal(input logic [2:0] op);
        return op[1:0] == 2'b11;
    endfunction

endpackage

// File: rtl/ex_stage_alu.sv
// alu: 32-bit logic/add/sub unit. unsig=1 selects signed semantics.
// compout is the a<b compare; overflow is signed overflow in signed mode,
// carry/borrow in unsigned mode, and 0 for non-arithmetic ops.
module alu
    import ex_pkg::*;
(
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [2:0]      op,
    input  logic            unsig,
    output logic [XLEN-1:0] aluout,
    output logic            compout,
    output logic            overflow
);

    logic [XLEN:0] sum;
    logic [XLEN:0] diff;
    logic          ov_add;
    logic          ov_sub;

    assign sum    = {1'b0, a} + {1'b0, b};
    assign diff   = {1'b0, a} + {1'b0, ~b} + {{XLEN{1'b0}}, 1'b1};
    assign ov_add = (a[XLEN-1] == b[XLEN-1]) && (sum[XLEN-1] != a[XLEN-1]);
    assign ov_sub = (a[XLEN-1] != b[XLEN-1]) && (diff[XLEN-1] != a[XLEN-1]);

    // Less-than from the subtractor: sign^overflow when signed, borrow when unsigned.
    assign compout = unsig ? (diff[XLEN-1] ^ ov_sub) : ~diff[XLEN];

    // Result mux; illegal op codes produce zero.
    always_comb begin
        aluout = '0;
        case (op)
            OP_AND:  aluout = a & b;
            OP_OR:   aluout = a | b;
            OP_ADD:  aluout = sum[XLEN-1:0];
            OP_NOR:  aluout = ~(a | b);
            OP_XOR:  aluout = a ^ b;
            OP_SUB:  aluout = diff[XLEN-1:0];
            default: aluout = '0;
        endcase
    end

    // Overflow flag for the two arithmetic ops only.
    always_comb begin
        overflow = 1'b0;
        case (op)
            OP_ADD:  overflow = unsig ? ov_add : sum[XLEN];
            OP_SUB:  overflow = unsig ? ov_sub : ~diff[XLEN];
            default: overflow = 1'b0;
        endcase
    end

endmodule

// File: rtl/ex_stage.sv
// ex_stage: one-entry execute pipeline register around the alu with exception
// cause reporting and a saturating signed-overflow counter.
// EX_STAGE_TRAP_EN: when defined, a faulting instruction parks in TRAP, then HALT
// until trap_clr; when undefined faults flow through like normal results.
module ex_stage
    import ex_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic             in_unsig,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [4:0]       in_rd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic             out_compout,
    output logic [4:0]       out_rd,
    output logic [1:0]       out_cause,
    input  logic             trap_clr,
    output logic [CNT_W-1:0] ovf_cnt
);

    logic [XLEN-1:0] alu_out;
    logic            alu_comp;
    logic            alu_ovf;
    logic            illegal;
    logic            arith_op;
    logic            accept;
    logic            retire;
    logic [1:0]      cause_nxt;
    logic [XLEN-1:0] result_nxt;
    state_t          state;
    state_t          acc_state;

    alu u_alu (
        .a        (in_a),
        .b        (in_b),
        .op       (in_op),
        .unsig    (in_unsig),
        .aluout   (alu_out),
        .compout  (alu_comp),
        .overflow (alu_ovf)
    );

    assign illegal    = is_illegal(in_op);
    assign arith_op   = (in_op == OP_ADD) || (in_op == OP_SUB);
    assign result_nxt = illegal ? '0 : alu_out;
    assign accept     = in_valid & in_ready;
    assign retire     = out_valid & out_ready;

    // Cause of the incoming instruction; illegal beats overflow, unsigned never overflows.
    always_comb begin
        cause_nxt = CAUSE_NONE;
        if (illegal)
            cause_nxt = CAUSE_ILL;
        else if (alu_ovf && in_unsig && arith_op)
            cause_nxt = CAUSE_OVF;
    end

    // Destination state for an accepted instruction.
`ifdef EX_STAGE_TRAP_EN
    assign acc_state = (cause_nxt == CAUSE_NONE) ? FULL : TRAP;
`else
    assign acc_state = FULL;
    logic trap_clr_unused;
    assign trap_clr_unused = trap_clr;
`endif

    // Accept only when empty, or when the held result leaves this same cycle.
    always_comb begin
        in_ready = 1'b0;
        case (state)
            IDLE:    in_ready = 1'b1;
            FULL:    in_ready = out_ready;
            default: in_ready = 1'b0;
        endcase
    end

    // Control FSM with registered out_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state     <= acc_state;
                        out_valid <= 1'b1;
                    end
                end
                FULL: begin
                    if (out_ready) begin
                        if (accept) begin
                            state <= acc_state;
                        end else begin
                            state     <= IDLE;
                            out_valid <= 1'b0;
                        end
                    end
                end
`ifdef EX_STAGE_TRAP_EN
                TRAP: begin
                    if (out_ready) begin
                        state     <= HALT;
                        out_valid <= 1'b0;
                    end
                end
                HALT: begin
                    if (trap_clr)
                        state <= IDLE;
                end
`endif
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    // Output register loads only on accept, so it holds steady under back-pressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_result  <= '0;
            out_compout <= 1'b0;
            out_rd      <= '0;
            out_cause   <= CAUSE_NONE;
        end else if (accept) begin
            out_result  <= result_nxt;
            out_compout <= alu_comp;
            out_rd      <= in_rd;
            out_cause   <= cause_nxt;
        end
    end

    // Count retired signed overflows, sticking at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ovf_cnt <= '0;
        else if (retire && (out_cause == CAUSE_OVF) && (ovf_cnt != '1))
            ovf_cnt <= ovf_cnt + CNT_W'(1);
    end

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: table-driven vectors plus hand sequences for trap, back-pressure
// and reset; results checked through an in-order scoreboard at retire.
module tb_ex_stage;
    import ex_pkg::*;

    localparam int CW  = 2;
    localparam int SAT = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [2:0]    in_op = 3'b000;
    logic          in_unsig = 1'b0;
    logic [31:0]   in_a = '0;
    logic [31:0]   in_b = '0;
    logic [4:0]    in_rd = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [31:0]   out_result;
    logic          out_compout;
    logic [4:0]    out_rd;
    logic [1:0]    out_cause;
    logic          trap_clr = 1'b0;
    logic [CW-1:0] ovf_cnt;

    ex_stage #(.CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_unsig(in_unsig), .in_a(in_a), .in_b(in_b), .in_rd(in_rd),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_compout(out_compout), .out_rd(out_rd), .out_cause(out_cause),
        .trap_clr(trap_clr), .ovf_cnt(ovf_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic        unsig;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] res;
        logic        comp;
        logic [1:0]  cause;
    } vec_t;

    vec_t sb[$];
    int   checks = 0;
    int   passes = 0;
    int   model_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Retire monitor: pop expected result whenever the stage hands one over.
    always @(negedge clk) begin
        vec_t e;
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_retire", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("result", out_result, e.res);
                chk("compout", 32'(out_compout), 32'(e.comp));
                chk("rd", 32'(out_rd), 32'(e.rd));
                chk("cause", 32'(out_cause), 32'(e.cause));
                if (e.cause == CAUSE_OVF && model_cnt < SAT) model_cnt++;
            end
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input vec_t v, output int waits);
        logic rdy;
        in_valid = 1'b1;
        in_op = v.op; in_unsig = v.unsig; in_a = v.a; in_b = v.b; in_rd = v.rd;
        waits = 0;
        @(negedge clk);
        while (!in_ready && waits < 50) begin
            @(negedge clk);
            waits++;
        end
        rdy = in_ready;
        chk("accept", 32'(rdy), 32'd1);
        @(posedge clk);
        #1;
        if (rdy) sb.push_back(v);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        chk("drain", sb.size(), 32'd0);
        sync();
    endtask

    // After a faulting accept: TRAP cycle, HALT until trap_clr, then ready again.
    task automatic trap_recover();
`ifdef EX_STAGE_TRAP_EN
        @(negedge clk);
        chk("trap_out_valid", 32'(out_valid), 32'd1);
        chk("trap_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        chk("halt_out_valid", 32'(out_valid), 32'd0);
        chk("halt_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        chk("halt_hold", 32'(in_ready), 32'd0);
        sync();
        trap_clr = 1'b1;
        sync();
        trap_clr = 1'b0;
        @(negedge clk);
        chk("clr_in_ready", 32'(in_ready), 32'd1);
        sync();
`endif
    endtask

    initial begin
        vec_t tbl[13];
        vec_t v;
        vec_t b_vec;
        vec_t c_vec;
        int   w;

        tbl[0]  = '{OP_AND,  1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 5'd1,  32'hF000F000, 1'b1, CAUSE_NONE};
        tbl[1]  = '{OP_OR,   1'b1, 32'h12340000, 32'h00005678, 5'd2,  32'h12345678, 1'b0, CAUSE_NONE};
        tbl[2]  = '{OP_ADD,  1'b0, 32'h7FFFFFFF, 32'h00000001, 5'd3,  32'h80000000, 1'b0, CAUSE_NONE};
        tbl[3]  = '{OP_ADD,  1'b0, 32'hFFFFFFFF, 32'h00000001, 5'd4,  32'h00000000, 1'b0, CAUSE_NONE};
        tbl[4]  = '{OP_NOR,  1'b0, 32'h0F0F0000, 32'h000000FF, 5'd5,  32'hF0F0FF00, 1'b0, CAUSE_NONE};
        tbl[5]  = '{OP_XOR,  1'b1, 32'hAAAA5555, 32'hFFFF0000, 5'd6,  32'h55555555, 1'b1, CAUSE_NONE};
        tbl[6]  = '{OP_SUB,  1'b1, 32'h00000005, 32'h00000007, 5'd7,  32'hFFFFFFFE, 1'b1, CAUSE_NONE};
        tbl[7]  = '{OP_SUB,  1'b1, 32'h80000000, 32'h00000001, 5'd8,  32'h7FFFFFFF, 1'b1, CAUSE_OVF};
        tbl[8]  = '{OP_SUB,  1'b0, 32'h00000003, 32'h00000005, 5'd9,  32'hFFFFFFFE, 1'b1, CAUSE_NONE};
        tbl[9]  = '{OP_ILL0, 1'b0, 32'h00000005, 32'h00000003, 5'd10, 32'h00000000, 1'b0, CAUSE_ILL};
        tbl[10] = '{OP_ILL1, 1'b1, 32'h7FFFFFFF, 32'h00000001, 5'd11, 32'h00000000, 1'b0, CAUSE_ILL};
        tbl[11] = '{OP_ADD,  1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd12, 32'hFFFFFFFE, 1'b0, CAUSE_NONE};
        tbl[12] = '{OP_SUB,  1'b0, 32'h00000050, 32'h00000010, 5'd13, 32'h00000040, 1'b0, CAUSE_NONE};

        // Reset values
        #1 rst_n = 1'b0;
        #11;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", out_result, 32'd0);
        chk("rst_cause", 32'(out_cause), 32'd0);
        chk("rst_rd", 32'(out_rd), 32'd0);
        chk("rst_ovf_cnt", 32'(ovf_cnt), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("in_ready_after_reset", 32'(in_ready), 32'd1);
        sync();
        out_ready = 1'b1;

        // Signed overflow add
        v = '{OP_ADD, 1'b1, 32'h7FFFFFFF, 32'h00000001, 5'd20, 32'h80000000, 1'b0, CAUSE_OVF};
        send(v, w);
`ifdef EX_STAGE_TRAP_EN
        trap_recover();
`else
        v = '{OP_ADD, 1'b0, 32'h7FFFFFFF, 32'h00000001, 5'd21, 32'h80000000, 1'b0, CAUSE_NONE};
        send(v, w);
        chk("next_accept_wait", 32'(w), 32'd0);
`endif
        drain();
        chk("ovf_cnt_first", 32'(ovf_cnt), 32'd1);

        // Vector table, streamed with out_ready held high
        for (int i = 0; i < 13; i++) begin
            send(tbl[i], w);
            if (tbl[i].cause != CAUSE_NONE) trap_recover();
        end
        drain();
        chk("ovf_cnt_table", 32'(ovf_cnt), 32'(model_cnt));
        chk("ovf_cnt_table_abs", 32'(ovf_cnt), 32'd2);

        // Back-pressure: hold for 3 cycles, then stream with no bubble
        out_ready = 1'b0;
        v     = '{OP_ADD, 1'b0, 32'd10,    32'd20,    5'd14, 32'd30,    1'b1, CAUSE_NONE};
        b_vec = '{OP_ADD, 1'b0, 32'h100,   32'h200,   5'd15, 32'h300,   1'b1, CAUSE_NONE};
        c_vec = '{OP_SUB, 1'b0, 32'h50,    32'h10,    5'd16, 32'h40,    1'b0, CAUSE_NONE};
        send(v, w);
        in_valid = 1'b1; in_op = b_vec.op; in_unsig = b_vec.unsig;
        in_a = b_vec.a; in_b = b_vec.b; in_rd = b_vec.rd;
        trap_clr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_out_valid", 32'(out_valid), 32'd1);
            chk("stall_result", out_result, 32'd30);
            chk("stall_rd", 32'(out_rd), 32'd14);
            sync();
            trap_clr = 1'b0;
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("release_in_ready", 32'(in_ready), 32'd1);
        sync();
        sb.push_back(b_vec);
        in_op = c_vec.op; in_unsig = c_vec.unsig;
        in_a = c_vec.a; in_b = c_vec.b; in_rd = c_vec.rd;
        @(negedge clk);
        chk("nobubble_valid", 32'(out_valid), 32'd1);
        chk("nobubble_rd", 32'(out_rd), 32'd15);
        chk("nobubble_in_ready", 32'(in_ready), 32'd1);
        sync();
        sb.push_back(c_vec);
        in_valid = 1'b0;
        @(negedge clk);
        chk("stream_c_valid", 32'(out_valid), 32'd1);
        drain();

        // Saturation of the overflow counter
        for (int i = 0; i < 3; i++) begin
            v = '{OP_ADD, 1'b1, 32'h40000000, 32'h40000000, 5'(24 + i), 32'h80000000, 1'b0, CAUSE_OVF};
            send(v, w);
            trap_recover();
        end
        drain();
        chk("ovf_cnt_sat", 32'(ovf_cnt), 32'(SAT));
        chk("ovf_cnt_model", 32'(ovf_cnt), 32'(model_cnt));

        // Asynchronous reset while FULL discards the held instruction
        out_ready = 1'b0;
        v = '{OP_OR, 1'b0, 32'h0000000F, 32'h000000F0, 5'd30, 32'h000000FF, 1'b1, CAUSE_NONE};
        send(v, w);
        @(negedge clk);
        chk("pre_reset_valid", 32'(out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(out_valid), 32'd0);
        chk("async_rst_result", out_result, 32'd0);
        chk("async_rst_ovf", 32'(ovf_cnt), 32'd0);
        chk("async_rst_rd", 32'(out_rd), 32'd0);
        sb.delete();
        model_cnt = 0;
        #3 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        chk("post_rst_valid", 32'(out_valid), 32'd0);
        sync();
        out_ready = 1'b1;
        send(tbl[5], w);
        drain();
        chk("final_ovf_cnt", 32'(ovf_cnt), 32'(model_cnt));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
